// File: rtl/s444_mon_pkg.sv
// Shared definitions for the s444 lamp monitor.
// Holds the phase codes, fault codes, lamp patterns, FSM state type and the
// legal phase-step function. The decoder, the monitor top and the bench
// all import it.
package s444_mon_pkg;

    // Phase codes reported on PHASE
    localparam logic [2:0] PH_MG_FR   = 3'd0;
    localparam logic [2:0] PH_MY_FR   = 3'd1;
    localparam logic [2:0] PH_ALL_RED = 3'd2;
    localparam logic [2:0] PH_MR_FG   = 3'd3;
    localparam logic [2:0] PH_MR_FY   = 3'd4;
    localparam logic [2:0] PH_INVALID = 3'd7;

    // Fault codes reported on FCODE
    localparam logic [2:0] F_NONE           = 3'd0;
    localparam logic [2:0] F_ILLEGAL        = 3'd1;
    localparam logic [2:0] F_BAD_TRANSITION = 3'd2;
    localparam logic [2:0] F_SHORT_GREEN    = 3'd3;
    localparam logic [2:0] F_SHORT_YELLOW   = 3'd4;
    localparam logic [2:0] F_WATCHDOG       = 3'd5;

    // Sampled lamp vector layout: {MR, MY, MG, FR, FY, FG}
    localparam logic [5:0] LAMP_MG_FR   = 6'b001_100;
    localparam logic [5:0] LAMP_MY_FR   = 6'b010_100;
    localparam logic [5:0] LAMP_ALL_RED = 6'b100_100;
    localparam logic [5:0] LAMP_MR_FG   = 6'b100_001;
    localparam logic [5:0] LAMP_MR_FY   = 6'b100_010;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_t;

    // True when moving from from_ph to to_ph is an allowed step.
    // Remaining in the same phase is always allowed.
    function automatic logic legal_step(input logic [2:0] from_ph,
                                        input logic [2:0] to_ph);
        logic ok;
        ok = 1'b0;
        case ({from_ph, to_ph})
            {PH_MG_FR,   PH_MY_FR},
            {PH_MY_FR,   PH_ALL_RED},
            {PH_ALL_RED, PH_MG_FR},
            {PH_ALL_RED, PH_MR_FG},
            {PH_MR_FG,   PH_MR_FY},
            {PH_MR_FY,   PH_ALL_RED}: ok = 1'b1;
            default:                  ok = (from_ph == to_ph);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/s444_lamp_decode.sv
// Combinational lamp-pattern decoder.
// Maps a sampled lamp vector to a phase code. Only the five patterns with
// exactly one lamp per road and at least one road red are valid; anything
// else (dark road, two lamps on a road, both roads non-red) is INVALID.
//
// Ports:
//   lamp_q  in  6  sampled lamps {MR, MY, MG, FR, FY, FG}
//   phase   out 3  decoded phase code (7 = invalid)
module s444_lamp_decode
    import s444_mon_pkg::*;
(
    input  logic [5:0] lamp_q,
    output logic [2:0] phase
);

    always_comb begin
        phase = PH_INVALID;
        case (lamp_q)
            LAMP_MG_FR:   phase = PH_MG_FR;
            LAMP_MY_FR:   phase = PH_MY_FR;
            LAMP_ALL_RED: phase = PH_ALL_RED;
            LAMP_MR_FG:   phase = PH_MR_FG;
            LAMP_MR_FY:   phase = PH_MR_FY;
            default:      phase = PH_INVALID;
        endcase
    end

endmodule

// File: rtl/s444_lamp_monitor.sv
// Receiver-side checker for the s444 traffic-light lamp outputs.
// Samples the six lamps, decodes them into a phase, times each phase and
// latches the first ordering/duration violation as a sticky coded fault.
//
// state | meaning
// ------+---------------------------------------------------------------
// SYNC  | waiting for a valid phase; follows lamps, raises no faults
// TRACK | checking order, min green/yellow dwell and the watchdog
// FAULT | fault latched, FCODE frozen; phase/dwell keep tracking; CLR exits
//
// Ports:
//   CK                 in   1   clock, rising edge
//   RST                in   1   asynchronous reset, active high
//   CLR                in   1   synchronous fault clear, restarts tracking
//   MR, MY, MG         in   1   main-road red / yellow / green lamps
//   FR, FY, FG         in   1   farm-road red / yellow / green lamps
//   PHASE              out  3   currently tracked phase (7 = invalid)
//   DWELL              out  CW  cycles spent in PHASE, saturating
//   FAULT              out  1   sticky fault flag
//   FCODE              out  3   code of the first fault, 0 = none
//   CYCLES             out  8   completed all-red -> main-green sequences, wraps
//
// MAX_DWELL must be below 2^CW so the watchdog can fire before saturation.
module s444_lamp_monitor
    import s444_mon_pkg::*;
#(
    parameter int CW         = 8,
    parameter int MIN_GREEN  = 8,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_DWELL  = 200
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          CLR,
    input  logic          MR,
    input  logic          MY,
    input  logic          MG,
    input  logic          FR,
    input  logic          FY,
    input  logic          FG,
    output logic [2:0]    PHASE,
    output logic [CW-1:0] DWELL,
    output logic          FAULT,
    output logic [2:0]    FCODE,
    output logic [7:0]    CYCLES
);

    localparam logic [CW-1:0] MIN_G     = CW'(MIN_GREEN);
    localparam logic [CW-1:0] MIN_Y     = CW'(MIN_YELLOW);
    localparam logic [CW:0]   MAX_D     = (CW+1)'(MAX_DWELL);
    localparam logic [CW-1:0] DWELL_SAT = '1;
    localparam logic [CW-1:0] DWELL_ONE = CW'(1);

    logic [5:0]    lamp_q;
    logic [2:0]    cur;
    mon_state_t    state;

    logic          phase_change;
    logic          leaving_green;
    logic          leaving_yellow;
    logic [CW:0]   dwell_p1;
    logic [CW-1:0] dwell_next;
    logic [2:0]    fcode_det;

    s444_lamp_decode u_decode (
        .lamp_q (lamp_q),
        .phase  (cur)
    );

    always_comb begin
        phase_change   = (cur != PHASE);
        leaving_green  = phase_change && ((PHASE == PH_MG_FR) || (PHASE == PH_MR_FG));
        leaving_yellow = phase_change && ((PHASE == PH_MY_FR) || (PHASE == PH_MR_FY));

        // One extra bit so the watchdog compare sees DWELL+1 without wrap.
        dwell_p1 = {1'b0, DWELL} + (CW+1)'(1);

        if (phase_change)
            dwell_next = DWELL_ONE;
        else if (DWELL == DWELL_SAT)
            dwell_next = DWELL;
        else
            dwell_next = dwell_p1[CW-1:0];

        // Priority chain: the lowest applicable code wins.
        fcode_det = F_NONE;
        if (cur == PH_INVALID)
            fcode_det = F_ILLEGAL;
        else if (phase_change && !legal_step(PHASE, cur))
            fcode_det = F_BAD_TRANSITION;
        else if (leaving_green && (DWELL < MIN_G))
            fcode_det = F_SHORT_GREEN;
        else if (leaving_yellow && (DWELL < MIN_Y))
            fcode_det = F_SHORT_YELLOW;
        else if (!phase_change && (dwell_p1 == MAX_D))
            fcode_det = F_WATCHDOG;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            lamp_q <= '0;
            state  <= ST_SYNC;
            PHASE  <= PH_INVALID;
            DWELL  <= '0;
            FAULT  <= 1'b0;
            FCODE  <= F_NONE;
            CYCLES <= '0;
        end else begin
            lamp_q <= {MR, MY, MG, FR, FY, FG};

            case (state)
                ST_SYNC: begin
                    PHASE <= cur;
                    if (cur != PH_INVALID) begin
                        // Restart timing from scratch on (re)acquisition,
                        // even if the phase matches the one held before CLR.
                        DWELL <= DWELL_ONE;
                        state <= ST_TRACK;
                    end else begin
                        DWELL <= dwell_next;
                    end
                end

                ST_TRACK: begin
                    PHASE <= cur;
                    DWELL <= dwell_next;
                    if ((PHASE == PH_ALL_RED) && (cur == PH_MG_FR))
                        CYCLES <= CYCLES + 8'd1;
                    if (fcode_det != F_NONE) begin
                        FAULT <= 1'b1;
                        FCODE <= fcode_det;
                        state <= ST_FAULT;
                    end
                end

                ST_FAULT: begin
                    PHASE <= cur;
                    DWELL <= dwell_next;
                end

                default: begin
                    state <= ST_SYNC;
                end
            endcase

            // Clear overrides any fault detected on this same edge.
            if (CLR) begin
                FAULT <= 1'b0;
                FCODE <= F_NONE;
                state <= ST_SYNC;
            end
        end
    end

endmodule

// File: tb/tb_s444_lamp_monitor.sv
// Directed self-checking bench for s444_lamp_monitor.
module tb_s444_lamp_monitor;

    logic       CK;
    logic       RST;
    logic       CLR;
    logic       MR, MY, MG, FR, FY, FG;
    logic [2:0] PHASE;
    logic [7:0] DWELL;
    logic       FAULT;
    logic [2:0] FCODE;
    logic [7:0] CYCLES;

    logic [5:0] tb_lamps;
    logic [2:0] dec_phase;

    int passed;
    int total;

    // Lamp vectors {MR, MY, MG, FR, FY, FG}
    localparam logic [5:0] P_MGFR  = 6'b001100;
    localparam logic [5:0] P_MYFR  = 6'b010100;
    localparam logic [5:0] P_ARED  = 6'b100100;
    localparam logic [5:0] P_MRFG  = 6'b100001;
    localparam logic [5:0] P_MRFY  = 6'b100010;
    localparam logic [5:0] P_MGFG  = 6'b001001;
    localparam logic [5:0] P_DARK  = 6'b000000;
    localparam logic [5:0] P_TWO   = 6'b110100;
    localparam logic [5:0] P_NORED = 6'b001010;

    s444_lamp_monitor #(
        .CW(8), .MIN_GREEN(8), .MIN_YELLOW(2), .MAX_DWELL(200)
    ) dut (
        .CK(CK), .RST(RST), .CLR(CLR),
        .MR(MR), .MY(MY), .MG(MG), .FR(FR), .FY(FY), .FG(FG),
        .PHASE(PHASE), .DWELL(DWELL), .FAULT(FAULT), .FCODE(FCODE), .CYCLES(CYCLES)
    );

    s444_lamp_decode u_ref_dec (
        .lamp_q (tb_lamps),
        .phase  (dec_phase)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CK);
            #1;
        end
    endtask

    task automatic set_lamps(input logic [5:0] v);
        {MR, MY, MG, FR, FY, FG} = v;
        tb_lamps = v;
    endtask

    task automatic hold(input logic [5:0] v, input int n);
        set_lamps(v);
        tick(n);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        CLR = 1'b0;
        set_lamps(P_DARK);
        tick(1);
        RST = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        RST    = 1'b1;
        CLR    = 1'b0;
        set_lamps(P_DARK);
        tick(2);

        // Reset values
        chk("rst_phase",  PHASE,  7);
        chk("rst_dwell",  DWELL,  0);
        chk("rst_fault",  FAULT,  0);
        chk("rst_fcode",  FCODE,  0);
        chk("rst_cycles", CYCLES, 0);

        // Reference decoder on representative patterns
        set_lamps(P_MGFR);  #1 chk("dec_mgfr",  dec_phase, 0);
        set_lamps(P_MRFY);  #1 chk("dec_mrfy",  dec_phase, 4);
        set_lamps(P_DARK);  #1 chk("dec_dark",  dec_phase, 7);
        set_lamps(P_TWO);   #1 chk("dec_two",   dec_phase, 7);
        set_lamps(P_NORED); #1 chk("dec_nored", dec_phase, 7);

        // Hold MG+FR for 10 cycles after reset release
        set_lamps(P_MGFR);
        RST = 1'b0;
        tick(1);
        chk("t1_phase_lat", PHASE, 7);
        tick(1);
        chk("t1_phase",  PHASE, 0);
        chk("t1_dwell1", DWELL, 1);
        tick(8);
        chk("t1_dwell9", DWELL, 9);
        chk("t1_fault",  FAULT, 0);

        // Full legal sequence at minimum durations
        do_reset();
        hold(P_MGFR, 8);
        chk("seq_g_phase", PHASE, 0);
        chk("seq_g_dwell", DWELL, 7);
        hold(P_MYFR, 2);
        chk("seq_y_phase", PHASE, 1);
        hold(P_ARED, 1);
        chk("seq_y_dwell", DWELL, 2);
        hold(P_MRFG, 1);
        chk("seq_ar_phase", PHASE, 2);
        hold(P_MRFG, 7);
        chk("seq_fg_phase", PHASE, 3);
        chk("seq_fg_dwell", DWELL, 7);
        hold(P_MRFY, 2);
        chk("seq_fy_phase", PHASE, 4);
        hold(P_ARED, 1);
        hold(P_MGFR, 1);
        chk("seq_ar2_phase", PHASE, 2);
        hold(P_MGFR, 1);
        chk("seq_back_phase", PHASE, 0);
        chk("seq_cycles", CYCLES, 1);
        chk("seq_fault",  FAULT, 0);

        // Reset asserted mid-yellow
        hold(P_MGFR, 7);
        hold(P_MYFR, 2);
        chk("rmy_phase", PHASE, 1);
        #2 RST = 1'b1;
        #1;
        chk("rmy_phase7", PHASE,  7);
        chk("rmy_dwell",  DWELL,  0);
        chk("rmy_cycles", CYCLES, 0);
        chk("rmy_fault",  FAULT,  0);
        RST = 1'b0;
        tick(1);
        chk("rmy_lat", PHASE, 7);
        tick(1);
        chk("rmy_resume", PHASE, 1);
        hold(P_ARED, 2);
        chk("rmy_ar_phase", PHASE, 2);
        chk("rmy_ar_fault", FAULT, 0);

        // Illegal pattern in TRACK, then CLR from FAULT
        do_reset();
        hold(P_MGFR, 10);
        hold(P_MGFG, 1);
        chk("ill_latency", FAULT, 0);
        hold(P_MGFR, 1);
        chk("ill_fault", FAULT, 1);
        chk("ill_fcode", FCODE, 1);
        chk("ill_phase", PHASE, 7);
        hold(P_MGFR, 1);
        chk("ill_track_phase", PHASE, 0);
        hold(P_ARED, 2);
        chk("ill_frozen", FCODE, 1);
        chk("ill_track2", PHASE, 2);
        CLR = 1'b1;
        tick(1);
        CLR = 1'b0;
        chk("clr_fault", FAULT, 0);
        chk("clr_fcode", FCODE, 0);
        chk("clr_dwell", DWELL, 2);
        tick(1);
        chk("sync_dwell", DWELL, 1);

        // CLR on the same edge as a 0->2 bad transition in TRACK
        hold(P_MGFR, 9);
        chk("pri_phase0", PHASE, 0);
        hold(P_ARED, 1);
        CLR = 1'b1;
        tick(1);
        CLR = 1'b0;
        chk("pri_fault", FAULT, 0);
        chk("pri_fcode", FCODE, 0);
        chk("pri_phase", PHASE, 2);
        tick(1);
        chk("pri_sync_dwell", DWELL, 1);
        chk("pri_fault2", FAULT, 0);

        // Bad transition 0->3 is caught once tracking resumes
        hold(P_MGFR, 9);
        hold(P_MRFG, 2);
        chk("bad_fault", FAULT, 1);
        chk("bad_fcode", FCODE, 2);

        // Green left after 7 cycles: one short of minimum
        do_reset();
        hold(P_MGFR, 7);
        hold(P_MYFR, 2);
        chk("sg_fcode", FCODE, 3);
        chk("sg_phase", PHASE, 1);

        // Yellow held only one cycle
        do_reset();
        hold(P_MGFR, 8);
        hold(P_MYFR, 1);
        hold(P_ARED, 1);
        chk("sy_pre", FAULT, 0);
        tick(1);
        chk("sy_fault", FAULT, 1);
        chk("sy_fcode", FCODE, 4);

        // Watchdog on a long all-red, then dwell saturation
        do_reset();
        hold(P_ARED, 200);
        chk("wd_dwell199", DWELL, 199);
        chk("wd_pre",      FAULT, 0);
        tick(1);
        chk("wd_dwell200", DWELL, 200);
        chk("wd_fault",    FAULT, 1);
        chk("wd_fcode",    FCODE, 5);
        tick(1);
        chk("wd_dwell201", DWELL, 201);
        tick(54);
        chk("wd_dwell255", DWELL, 255);
        tick(5);
        chk("wd_sat",      DWELL, 255);
        chk("wd_phase",    PHASE, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
